// File: rtl/riscv_mcycle_controller_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, datapath
// select codes, opcodes and the ALU operation codes.
package riscv_mcycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_ILLEGAL
  } state_t;

  typedef enum logic [1:0] {
    ALU_CLASS_ADD,
    ALU_CLASS_SUB,
    ALU_CLASS_FUNCT_R,
    ALU_CLASS_FUNCT_I
  } alu_class_t;

  localparam logic       ADR_PC       = 1'b0;
  localparam logic       ADR_RESULT   = 1'b1;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC  = 2'b01;
  localparam logic [1:0] SRC_A_RD1    = 2'b10;

  localparam logic [1:0] SRC_B_RD2    = 2'b00;
  localparam logic [1:0] SRC_B_IMM    = 2'b01;
  localparam logic [1:0] SRC_B_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUOUT   = 2'b00;
  localparam logic [1:0] RES_RDATA    = 2'b01;
  localparam logic [1:0] RES_ALU      = 2'b10;

  localparam logic [1:0] IMM_I        = 2'b00;
  localparam logic [1:0] IMM_S        = 2'b01;
  localparam logic [1:0] IMM_B        = 2'b10;
  localparam logic [1:0] IMM_J        = 2'b11;

  localparam logic [6:0] OP_LW        = 7'b0000011;
  localparam logic [6:0] OP_SW        = 7'b0100011;
  localparam logic [6:0] OP_RTYPE     = 7'b0110011;
  localparam logic [6:0] OP_ITYPE     = 7'b0010011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;

  localparam logic [2:0] F3_BEQ       = 3'b000;
  localparam logic [2:0] F3_BNE       = 3'b001;
  localparam logic [2:0] F3_BLT       = 3'b100;
  localparam logic [2:0] F3_BGE       = 3'b101;
  localparam logic [2:0] F3_BLTU      = 3'b110;
  localparam logic [2:0] F3_BGEU      = 3'b111;

  localparam logic [3:0] ALU_OP_ADD   = 4'b0000;
  localparam logic [3:0] ALU_OP_SUB   = 4'b0001;
  localparam logic [3:0] ALU_OP_AND   = 4'b0010;
  localparam logic [3:0] ALU_OP_OR    = 4'b0011;
  localparam logic [3:0] ALU_OP_XOR   = 4'b0100;
  localparam logic [3:0] ALU_OP_SLL   = 4'b0101;
  localparam logic [3:0] ALU_OP_SRL   = 4'b0110;
  localparam logic [3:0] ALU_OP_SRA   = 4'b0111;
  localparam logic [3:0] ALU_OP_SLT   = 4'b1000;
  localparam logic [3:0] ALU_OP_SLTU  = 4'b1001;

endpackage

// File: rtl/riscv_mcycle_controller_alu_dec.sv
// ALU operation decoder: maps the state's ALU class plus funct3/funct7[5]
// onto an ALU op code.
module mcyc_alu_dec
  import riscv_mcycle_controller_pkg::*;
(
  input  alu_class_t alu_class,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_ctrl
);

  // funct7[5] selects sub only for R-type; for both classes it picks sra over srl.
  always_comb begin
    alu_ctrl = ALU_OP_ADD;
    case (alu_class)
      ALU_CLASS_ADD: alu_ctrl = ALU_OP_ADD;
      ALU_CLASS_SUB: alu_ctrl = ALU_OP_SUB;
      default: begin
        case (funct3)
          3'b000:  alu_ctrl = (alu_class == ALU_CLASS_FUNCT_R && funct7_5) ? ALU_OP_SUB : ALU_OP_ADD;
          3'b001:  alu_ctrl = ALU_OP_SLL;
          3'b010:  alu_ctrl = ALU_OP_SLT;
          3'b011:  alu_ctrl = ALU_OP_SLTU;
          3'b100:  alu_ctrl = ALU_OP_XOR;
          3'b101:  alu_ctrl = funct7_5 ? ALU_OP_SRA : ALU_OP_SRL;
          3'b110:  alu_ctrl = ALU_OP_OR;
          default: alu_ctrl = ALU_OP_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/riscv_mcycle_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// for a shared-ALU, single-memory datapath with a memory-ready handshake.
module riscv_mcycle_controller
  import riscv_mcycle_controller_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [3:0]  alu_flags,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        adr_src,
  output logic        mem_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  res_src,
  output logic [1:0]  imm_src,
  output logic [3:0]  alu_ctrl,
  output logic        illegal
);

  state_t     state, state_next;
  alu_class_t alu_class;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       branch_taken;
  logic       pc_we_int, mem_we_int, ir_we_int, reg_we_int, illegal_int;
  logic       unused_instr;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7_5 = instr[30];
  assign {flag_n, flag_z, flag_c, flag_v} = alu_flags;
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    case (funct3)
      F3_BEQ:  branch_taken = flag_z;
      F3_BNE:  branch_taken = !flag_z;
      F3_BLT:  branch_taken = flag_n ^ flag_v;
      F3_BGE:  branch_taken = !(flag_n ^ flag_v);
      F3_BLTU: branch_taken = !flag_c;
      F3_BGEU: branch_taken = flag_c;
      default: branch_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECR;
          OP_ITYPE:     state_next = S_EXECI;
          OP_BRANCH:    state_next = S_BRANCH;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_ILLEGAL:  state_next = S_ILLEGAL;
      default:    state_next = S_FETCH;
    endcase
  end

  // Don't-care selects default to zero so the outputs stay deterministic.
  always_comb begin
    pc_we_int   = 1'b0;
    mem_we_int  = 1'b0;
    ir_we_int   = 1'b0;
    reg_we_int  = 1'b0;
    illegal_int = 1'b0;
    adr_src     = ADR_PC;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_RD2;
    res_src     = RES_ALUOUT;
    imm_src     = IMM_I;
    alu_class   = ALU_CLASS_ADD;
    case (state)
      S_FETCH: begin
        adr_src   = ADR_PC;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        res_src   = RES_ALU;
        ir_we_int = mem_ready;
        pc_we_int = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
        imm_src   = (opcode == OP_SW) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        adr_src = ADR_RESULT;
        res_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        res_src    = RES_RDATA;
        reg_we_int = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = ADR_RESULT;
        res_src    = RES_ALUOUT;
        mem_we_int = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_RD2;
        alu_class = ALU_CLASS_FUNCT_R;
      end
      S_EXECI: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
        imm_src   = IMM_I;
        alu_class = ALU_CLASS_FUNCT_I;
      end
      S_ALUWB: begin
        res_src    = RES_ALUOUT;
        reg_we_int = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_RD2;
        alu_class = ALU_CLASS_SUB;
        res_src   = RES_ALUOUT;
        imm_src   = IMM_B;
        pc_we_int = branch_taken;
      end
      S_JAL: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_FOUR;
        res_src   = RES_ALUOUT;
        pc_we_int = 1'b1;
      end
      S_ILLEGAL:  illegal_int = 1'b1;
      default: ;
    endcase
  end

  // Enables are masked by reset so an abandoned access stops at once.
  assign pc_we   = pc_we_int   & rst_n;
  assign mem_we  = mem_we_int  & rst_n;
  assign ir_we   = ir_we_int   & rst_n;
  assign reg_we  = reg_we_int  & rst_n;
  assign illegal = illegal_int & rst_n;

  mcyc_alu_dec u_alu_dec (
    .alu_class (alu_class),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .alu_ctrl  (alu_ctrl)
  );

endmodule

// File: tb/tb_riscv_mcycle_controller.sv
// Directed bench for the multicycle controller; per-cycle expected outputs are
// queued when stimulus is driven and checked half a cycle later.
module tb_riscv_mcycle_controller;

  typedef struct packed {
    logic       pc_we;
    logic       adr_src;
    logic       mem_we;
    logic       ir_we;
    logic       reg_we;
    logic       illegal;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] res;
    logic [1:0] imm;
    logic [3:0] alu;
    logic       care_adr;
    logic       care_a;
    logic       care_b;
    logic       care_res;
    logic       care_imm;
    logic       care_alu;
  } exp_t;

  localparam logic [31:0] I_LW    = 32'hffc4a303;
  localparam logic [31:0] I_SW    = 32'h0064a423;
  localparam logic [31:0] I_ADD   = 32'h003180b3;
  localparam logic [31:0] I_SUB   = 32'h403180b3;
  localparam logic [31:0] I_OR    = 32'h0062e233;
  localparam logic [31:0] I_SRL   = 32'h0031d0b3;
  localparam logic [31:0] I_ADDI  = 32'h00500093;
  localparam logic [31:0] I_ADDIN = 32'hc0000093;
  localparam logic [31:0] I_SRAI  = 32'h4030d093;
  localparam logic [31:0] I_BEQ   = 32'hfe420ae3;
  localparam logic [31:0] I_BLT   = 32'h00314863;
  localparam logic [31:0] I_BGEU  = 32'h00317863;
  localparam logic [31:0] I_JAL   = 32'h008000ef;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic [3:0]  alu_flags;
  logic        mem_ready;
  logic        pc_we, adr_src, mem_we, ir_we, reg_we, illegal;
  logic [1:0]  alu_src_a, alu_src_b, res_src, imm_src;
  logic [3:0]  alu_ctrl;

  int    n_checks = 0;
  int    n_pass   = 0;
  string cur_name = "";
  exp_t  sb[$];

  always #5 clk = ~clk;

  riscv_mcycle_controller #(.HALT_ON_ILLEGAL(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .alu_flags (alu_flags),
    .mem_ready (mem_ready),
    .pc_we     (pc_we),
    .adr_src   (adr_src),
    .mem_we    (mem_we),
    .ir_we     (ir_we),
    .reg_we    (reg_we),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .res_src   (res_src),
    .imm_src   (imm_src),
    .alu_ctrl  (alu_ctrl),
    .illegal   (illegal)
  );

  function automatic exp_t e_base();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic exp_t e_fetch(input logic mr);
    exp_t e = e_base();
    e.adr_src = 1'b0; e.care_adr = 1'b1;
    e.a = 2'b00; e.care_a = 1'b1;
    e.b = 2'b10; e.care_b = 1'b1;
    e.res = 2'b10; e.care_res = 1'b1;
    e.alu = OP_ADD; e.care_alu = 1'b1;
    e.ir_we = mr; e.pc_we = mr;
    return e;
  endfunction

  function automatic exp_t e_decode(input logic is_jal);
    exp_t e = e_base();
    e.a = 2'b01; e.care_a = 1'b1;
    e.b = 2'b01; e.care_b = 1'b1;
    e.alu = OP_ADD; e.care_alu = 1'b1;
    e.imm = is_jal ? 2'b11 : 2'b10; e.care_imm = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_memadr(input logic is_sw);
    exp_t e = e_base();
    e.a = 2'b10; e.care_a = 1'b1;
    e.b = 2'b01; e.care_b = 1'b1;
    e.alu = OP_ADD; e.care_alu = 1'b1;
    e.imm = is_sw ? 2'b01 : 2'b00; e.care_imm = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_memacc(input logic is_write);
    exp_t e = e_base();
    e.adr_src = 1'b1; e.care_adr = 1'b1;
    e.res = 2'b00; e.care_res = 1'b1;
    e.mem_we = is_write;
    return e;
  endfunction

  function automatic exp_t e_wb(input logic from_mem);
    exp_t e = e_base();
    e.res = from_mem ? 2'b01 : 2'b00; e.care_res = 1'b1;
    e.reg_we = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_exec(input logic is_r, input logic [3:0] op);
    exp_t e = e_base();
    e.a = 2'b10; e.care_a = 1'b1;
    e.b = is_r ? 2'b00 : 2'b01; e.care_b = 1'b1;
    e.alu = op; e.care_alu = 1'b1;
    e.imm = 2'b00; e.care_imm = !is_r;
    return e;
  endfunction

  function automatic exp_t e_branch(input logic taken);
    exp_t e = e_base();
    e.a = 2'b10; e.care_a = 1'b1;
    e.b = 2'b00; e.care_b = 1'b1;
    e.alu = OP_SUB; e.care_alu = 1'b1;
    e.res = 2'b00; e.care_res = 1'b1;
    e.imm = 2'b10; e.care_imm = 1'b1;
    e.pc_we = taken;
    return e;
  endfunction

  function automatic exp_t e_jal();
    exp_t e = e_base();
    e.a = 2'b01; e.care_a = 1'b1;
    e.b = 2'b10; e.care_b = 1'b1;
    e.alu = OP_ADD; e.care_alu = 1'b1;
    e.res = 2'b00; e.care_res = 1'b1;
    e.pc_we = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_illegal();
    exp_t e = e_base();
    e.illegal = 1'b1;
    return e;
  endfunction

  task automatic chk(input string field, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s.%s: observed %0h expected %0h", cur_name, field, obs, exp);
  endtask

  task automatic apply_stimulus(input string name, input logic [31:0] i,
                                input logic [3:0] f, input logic mr, input exp_t e);
    cur_name  = name;
    instr     = i;
    alu_flags = f;
    mem_ready = mr;
    sb.push_back(e);
  endtask

  task automatic check_output();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $error("[TB] FAIL %s.scoreboard: observed empty expected entry", cur_name);
      return;
    end
    e = sb.pop_front();
    chk("pc_we",   {3'b0, pc_we},   {3'b0, e.pc_we});
    chk("mem_we",  {3'b0, mem_we},  {3'b0, e.mem_we});
    chk("ir_we",   {3'b0, ir_we},   {3'b0, e.ir_we});
    chk("reg_we",  {3'b0, reg_we},  {3'b0, e.reg_we});
    chk("illegal", {3'b0, illegal}, {3'b0, e.illegal});
    if (e.care_adr) chk("adr_src",   {3'b0, adr_src}, {3'b0, e.adr_src});
    if (e.care_a)   chk("alu_src_a", {2'b0, alu_src_a}, {2'b0, e.a});
    if (e.care_b)   chk("alu_src_b", {2'b0, alu_src_b}, {2'b0, e.b});
    if (e.care_res) chk("res_src",   {2'b0, res_src},   {2'b0, e.res});
    if (e.care_imm) chk("imm_src",   {2'b0, imm_src},   {2'b0, e.imm});
    if (e.care_alu) chk("alu_ctrl",  alu_ctrl, e.alu);
  endtask

  task automatic step(input string name, input logic [31:0] i,
                      input logic [3:0] f, input logic mr, input exp_t e);
    apply_stimulus(name, i, f, mr, e);
    @(negedge clk);
    check_output();
    @(posedge clk);
    #1;
  endtask

  task automatic run_rtype(input string name, input logic [31:0] i, input logic [3:0] op);
    step({name, "_fetch"},  i, 4'b0, 1'b1, e_fetch(1'b1));
    step({name, "_decode"}, i, 4'b0, 1'b1, e_decode(1'b0));
    step({name, "_exec"},   i, 4'b0, 1'b1, e_exec(1'b1, op));
    step({name, "_wb"},     i, 4'b0, 1'b1, e_wb(1'b0));
  endtask

  task automatic run_itype(input string name, input logic [31:0] i, input logic [3:0] op);
    step({name, "_fetch"},  i, 4'b0, 1'b1, e_fetch(1'b1));
    step({name, "_decode"}, i, 4'b0, 1'b1, e_decode(1'b0));
    step({name, "_exec"},   i, 4'b0, 1'b1, e_exec(1'b0, op));
    step({name, "_wb"},     i, 4'b0, 1'b1, e_wb(1'b0));
  endtask

  task automatic run_branch(input string name, input logic [31:0] i,
                            input logic [3:0] f, input logic taken);
    step({name, "_fetch"},  i, f, 1'b1, e_fetch(1'b1));
    step({name, "_decode"}, i, f, 1'b1, e_decode(1'b0));
    step({name, "_branch"}, i, f, 1'b1, e_branch(taken));
  endtask

  task automatic pulse_reset(input string name);
    apply_stimulus(name, 32'h0, 4'b0, 1'b0, e_base());
    rst_n = 1'b0;
    #1;
    check_output();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    instr     = 32'h0;
    alu_flags = 4'b0;
    mem_ready = 1'b1;

    apply_stimulus("reset", 32'h0, 4'b0, 1'b1, e_base());
    #7;
    check_output();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    step("lw_fetch_stall", I_LW, 4'b0, 1'b0, e_fetch(1'b0));
    step("lw_fetch",       I_LW, 4'b0, 1'b1, e_fetch(1'b1));
    step("lw_decode",      I_LW, 4'b0, 1'b1, e_decode(1'b0));
    step("lw_memadr",      I_LW, 4'b0, 1'b1, e_memadr(1'b0));
    step("lw_memread",     I_LW, 4'b0, 1'b1, e_memacc(1'b0));
    step("lw_memwb",       I_LW, 4'b0, 1'b1, e_wb(1'b1));

    step("sw_fetch",       I_SW, 4'b0, 1'b1, e_fetch(1'b1));
    step("sw_decode",      I_SW, 4'b0, 1'b1, e_decode(1'b0));
    step("sw_memadr",      I_SW, 4'b0, 1'b1, e_memadr(1'b1));
    step("sw_memwrite0",   I_SW, 4'b0, 1'b0, e_memacc(1'b1));
    step("sw_memwrite1",   I_SW, 4'b0, 1'b0, e_memacc(1'b1));
    step("sw_memwrite2",   I_SW, 4'b0, 1'b1, e_memacc(1'b1));

    run_rtype("add", I_ADD, OP_ADD);
    run_rtype("sub", I_SUB, OP_SUB);
    run_rtype("or",  I_OR,  OP_OR);
    run_rtype("srl", I_SRL, OP_SRL);

    run_itype("addi",     I_ADDI,  OP_ADD);
    run_itype("addi_neg", I_ADDIN, OP_ADD);
    run_itype("srai",     I_SRAI,  OP_SRA);

    run_branch("beq_t",  I_BEQ,  4'b0100, 1'b1);
    run_branch("beq_nt", I_BEQ,  4'b0000, 1'b0);
    run_branch("blt_t",  I_BLT,  4'b1000, 1'b1);
    run_branch("blt_nt", I_BLT,  4'b1001, 1'b0);
    run_branch("bgeu_t", I_BGEU, 4'b0010, 1'b1);

    step("jal_fetch",  I_JAL, 4'b0, 1'b1, e_fetch(1'b1));
    step("jal_decode", I_JAL, 4'b0, 1'b1, e_decode(1'b1));
    step("jal_jal",    I_JAL, 4'b0, 1'b1, e_jal());
    step("jal_wb",     I_JAL, 4'b0, 1'b1, e_wb(1'b0));

    step("ill_fetch",  32'h0, 4'b0, 1'b1, e_fetch(1'b1));
    step("ill_decode", 32'h0, 4'b0, 1'b1, e_decode(1'b0));
    for (int k = 0; k < 10; k++)
      step($sformatf("ill_hold%0d", k), 32'h0, 4'b0, 1'b1, e_illegal());
    pulse_reset("ill_reset");
    step("ill_after_reset", I_SW, 4'b0, 1'b1, e_fetch(1'b1));

    step("rst_sw_decode",   I_SW, 4'b0, 1'b1, e_decode(1'b0));
    step("rst_sw_memadr",   I_SW, 4'b0, 1'b1, e_memadr(1'b1));
    step("rst_sw_memwrite", I_SW, 4'b0, 1'b0, e_memacc(1'b1));
    pulse_reset("rst_mid_write");
    step("rst_after_write", I_SW, 4'b0, 1'b1, e_fetch(1'b1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
